mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Job-level controller for the 8-bit ALU's multiply-accumulate operation (opcode 4'b0110, acc += A*B).
//  Accepts a job (length N), clears the ALU accumulator, then streams N operand pairs into the ALU.
//  Returns the final accumulator value over a valid/ready result handshake.
//  Sits between the operand source and the ALU. Needs the ALU revision that adds the acc_clr input.
// PARAMETERS
//  WIDTH    8        operand / accumulator width
//  LEN_W    4        job-length counter width (max N = 2**LEN_W-1)
//  TIMEOUT  16       idle-operand cycles before abort (MAC_TIMEOUT_EN only)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      reset; asynchronous, active-high
//  start        in   1      job request; sampled only in IDLE
//  len          in   LEN_W  operand-pair count, sampled with start
//  busy         out  1      1 in every state except IDLE
//  op_valid     in   1      operand pair available
//  op_ready     out  1      sequencer accepts operand pair
//  op_a, op_b   in   WIDTH  operand pair
//  res_valid    out  1      result available
//  res_ready    in   1      consumer takes result
//  res_data     out  WIDTH  accumulated result
//  res_err      out  1      job aborted by timeout; constant 0 without MAC_TIMEOUT_EN
//  alu_a, alu_b out  WIDTH  to ALU A/B
//  alu_opcode   out  4      to ALU opcode
//  alu_acc_clr  out  1      to ALU accumulator clear
//  alu_out      in   WIDTH  from ALU ALU_Out, registered by the ALU
// BEHAVIOUR
//  Reset values: state=IDLE; busy, op_ready, res_valid, res_err, alu_acc_clr = 0.
//  Reset values: res_data, alu_a, alu_b, remaining count = 0; alu_opcode=OP_NOP.
//  Reset does not touch the ALU accumulator; every job starts with CLEAR.
//  Reset mid-job abandons the job immediately. No result is produced for it.
//  FSM: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: on start=1, latch len and go to CLEAR.
//  CLEAR: alu_acc_clr=1 for exactly one cycle. Go to RUN if len!=0, else to DRAIN.
//  RUN: op_ready=1. On op_valid&&op_ready: alu_opcode=OP_MAC, alu_a=op_a, alu_b=op_b (combinational); decrement count.
//  RUN: on any other cycle, alu_opcode=OP_NOP and alu_a=alu_b=0.
//  RUN: the handshake that accepts the last pair moves to DRAIN. op_ready is 0 outside RUN.
//  DRAIN: one cycle; alu_out now holds the final acc. Register it into res_data and go to DONE.
//  DONE: res_valid=1. res_data and res_err stay stable until res_ready=1, then go to IDLE.
//  start outside IDLE is ignored, including the DONE->IDLE handoff cycle.
//  Latency, op_valid held high: start at cycle 0 -> res_valid at cycle N+3.
//  Arithmetic is the ALU's: result mod 2**WIDTH, no saturation, no overflow flag.
// CONFIGURATION
//  MAC_TIMEOUT_EN defined: a RUN-state counter counts consecutive cycles with op_valid=0.
//    The counter clears on every handshake.
//    When it reaches TIMEOUT: go to DONE with res_err=1 and res_data=0.
//    res_err clears when the result is accepted.
//  MAC_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; res_err is tied 0.
// STRUCTURE
//  Package mac_pkg: OP_MAC=4'b0110, OP_NOP=4'b1111 (ALU holds acc), state typedef {IDLE,CLEAR,RUN,DRAIN,DONE}.
//  Single module. Timeout counter is inline under the macro; no sub-module.
// TESTING (ALU model or real ALU attached)
//  T1 len=3, pairs (1,2),(10,5),(34,25), op_valid always 1 -> res_data=134 (902 mod 256), res_valid at cycle 6.
//  T2 T1 pairs with a 2-cycle op_valid gap and res_ready low for 5 cycles.
//     Required: alu_opcode=OP_NOP during the gap, res_data=134 held stable until accepted.
//  T3 len=0 -> one alu_acc_clr pulse, OP_MAC never issued, res_data=0 at cycle 3.
//  T4 pulse start in RUN -> ignored.
//     rst asserted mid-RUN -> all outputs at reset values in the same cycle.
//     Next job len=1, pair (3,4) -> res_data=12.
//  T5 wrap: len=2, pairs (255,255),(255,255) -> res_data=2.
//  T6 MAC_TIMEOUT_EN: len=2, one pair, then op_valid=0 for 16 cycles -> res_valid=1, res_err=1, res_data=0.
//     Without the macro: still busy and in RUN after 100 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared opcodes and state encoding for the MAC job sequencer.
package mac_pkg;

    localparam logic [3:0] OP_MAC = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Job-level controller streaming N operand pairs into the ALU multiply-accumulate.
// Optional build macro MAC_TIMEOUT_EN adds an idle-operand abort in RUN.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_acc_clr,
    input  logic [WIDTH-1:0] alu_out
);

    if (LEN_W == 0 || TIMEOUT == 0) begin : g_param_check
        $error("mac_sequencer: LEN_W and TIMEOUT must be non-zero");
    end

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             accept_c;

    assign accept_c = (state == RUN) && op_valid && op_ready;

    // ALU drive is combinational so the pair lands in the same cycle it is accepted
    always_comb begin
        alu_opcode = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        if (accept_c) begin
            alu_opcode = OP_MAC;
            alu_a      = op_a;
            alu_b      = op_b;
        end
    end

`ifdef MAC_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            timeout_c;

    assign timeout_c = (state == RUN) && !op_valid && (idle_cnt == TO_W'(TIMEOUT - 1));
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            op_ready    <= 1'b0;
            res_valid   <= 1'b0;
            alu_acc_clr <= 1'b0;
            res_data    <= '0;
            remaining   <= '0;
`ifdef MAC_TIMEOUT_EN
            res_err     <= 1'b0;
            idle_cnt    <= '0;
`endif
        end else begin
            alu_acc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= len;
                        busy        <= 1'b1;
                        alu_acc_clr <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
`ifdef MAC_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (remaining != '0) begin
                        op_ready <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= DRAIN;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        remaining <= remaining - LEN_W'(1);
`ifdef MAC_TIMEOUT_EN
                        idle_cnt  <= '0;
`endif
                        if (remaining == LEN_W'(1)) begin
                            op_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
`ifdef MAC_TIMEOUT_EN
                    else if (timeout_c) begin
                        // abandon the job and report an error result with zero data
                        op_ready  <= 1'b0;
                        remaining <= '0;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_data  <= '0;
                        state     <= DONE;
                    end else if (!op_valid) begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
`endif
                end
                DRAIN: begin
                    // the ALU has registered the last MAC; its output is the final sum
                    res_data  <= alu_out;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
`ifdef MAC_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised self-checking bench for mac_sequencer with a behavioural ALU accumulator.
module tb_mac_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;
    localparam logic [3:0] MAC_OP = 4'b0110;
    localparam logic [3:0] NOP_OP = 4'b1111;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_opcode;
    logic             alu_acc_clr;
    logic [WIDTH-1:0] alu_out;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    int               qgap[$];

    int obs_lat, obs_mac, obs_clr, obs_ab_bad, obs_gap_bad, obs_unstable;
    int obs_data, obs_err, obs_post_busy, obs_timed_out;

    always #5 clk = ~clk;

    mac_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_acc_clr(alu_acc_clr),
        .alu_out(alu_out)
    );

    // ALU accumulator: clear, multiply-accumulate mod 2**WIDTH, otherwise hold
    logic [WIDTH-1:0] acc;
    always @(posedge clk) begin
        if (alu_acc_clr) acc <= '0;
        else if (alu_opcode == MAC_OP) acc <= acc + alu_a * alu_b;
    end
    assign alu_out = acc;

    function automatic int ref_sum();
        int s = 0;
        foreach (qa[i]) s += int'(qa[i]) * int'(qb[i]);
        return s % 256;
    endfunction

    function automatic int ref_latency(input int n);
        int g = 0;
        if (n == 0) return 3;
        for (int i = 0; i < n && i < qgap.size(); i++) g += qgap[i];
        return n + 3 + g;
    endfunction

    // drive one job through start, operand stream and result handshake, recording observations
    task automatic run_job(input int n, input int rdly, input int budget, input bit start_at_accept);
        int idx, gap, cyc, wait_cnt;
        bit seen, accept;
        logic [WIDTH-1:0] held;
        logic held_err;
        idx = 0; cyc = 0; wait_cnt = 0; seen = 0; accept = 0; held = '0; held_err = 1'b0;
        gap = (qgap.size() > 0) ? qgap[0] : 0;
        obs_lat = -1; obs_mac = 0; obs_clr = 0; obs_ab_bad = 0; obs_gap_bad = 0;
        obs_unstable = 0; obs_data = -1; obs_err = 0; obs_post_busy = 0; obs_timed_out = 0;
        start = 1'b1;
        len = LEN_W'(n);
        while (!accept) begin
            if (res_valid) begin
                if (!seen) begin
                    seen = 1; obs_lat = cyc; held = res_data; held_err = res_err;
                    obs_data = int'(res_data); obs_err = int'(res_err);
                end else if (res_data !== held || res_err !== held_err) begin
                    obs_unstable++;
                end
            end
            accept = seen && (wait_cnt >= rdly);
            if (seen) wait_cnt++;
            res_ready = accept;
            if (accept && start_at_accept) start = 1'b1;
            if (idx < n && gap == 0) begin
                op_valid = 1'b1; op_a = qa[idx]; op_b = qb[idx];
            end else begin
                op_valid = 1'b0;
            end
            #1;
            if (alu_acc_clr) obs_clr++;
            if ((alu_opcode == MAC_OP) !== (op_valid && op_ready)) obs_ab_bad++;
            if (alu_opcode == MAC_OP) begin
                obs_mac++;
                if (alu_a !== op_a || alu_b !== op_b) obs_ab_bad++;
            end else if (alu_opcode !== NOP_OP || alu_a !== '0 || alu_b !== '0) begin
                obs_gap_bad++;
            end
            if (op_valid && op_ready) begin
                idx++;
                gap = (idx < qgap.size()) ? qgap[idx] : 0;
            end else if (op_ready && gap > 0) begin
                gap--;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (!accept && cyc >= budget) begin
                obs_timed_out = 1; op_valid = 1'b0;
                return;
            end
        end
        res_ready = 1'b0;
        op_valid = 1'b0;
        obs_post_busy = int'(busy) + int'(res_valid);
        @(posedge clk); #1;
        obs_post_busy += int'(busy) + int'(alu_acc_clr);
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, op_ready, res_valid, res_err, alu_acc_clr, res_data, alu_a, alu_b, alu_opcode}
            !== {5'b0, 24'h0, NOP_OP}) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b rdy=%b rv=%b err=%b clr=%b data=%0d a=%0d b=%0d op=%h",
                     busy, op_ready, res_valid, res_err, alu_acc_clr, res_data, alu_a, alu_b, alu_opcode);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        qa = '{8'd1, 8'd10, 8'd34}; qb = '{8'd2, 8'd5, 8'd25}; qgap = '{0, 0, 0};
        run_job(3, 0, 200, 0);
        vectors++; if (obs_data !== 134) begin miscompares++; $display("FAIL t1_data got=%0d exp=134", obs_data); end
        vectors++; if (obs_lat !== 6) begin miscompares++; $display("FAIL t1_latency got=%0d exp=6", obs_lat); end
        vectors++; if (obs_mac !== 3 || obs_clr !== 1) begin miscompares++; $display("FAIL t1_issue got mac=%0d clr=%0d exp mac=3 clr=1", obs_mac, obs_clr); end
        vectors++; if (obs_ab_bad !== 0 || obs_gap_bad !== 0) begin miscompares++; $display("FAIL t1_alu_drive got bad=%0d/%0d exp 0", obs_ab_bad, obs_gap_bad); end
        vectors++; if (obs_post_busy !== 0) begin miscompares++; $display("FAIL t1_return_idle got=%0d exp=0", obs_post_busy); end
    endtask

    task automatic test_gap_backpressure();
        qa = '{8'd1, 8'd10, 8'd34}; qb = '{8'd2, 8'd5, 8'd25}; qgap = '{0, 2, 0};
        run_job(3, 5, 200, 0);
        vectors++; if (obs_data !== 134) begin miscompares++; $display("FAIL t2_data got=%0d exp=134", obs_data); end
        vectors++; if (obs_lat !== 8) begin miscompares++; $display("FAIL t2_latency got=%0d exp=8", obs_lat); end
        vectors++; if (obs_gap_bad !== 0 || obs_ab_bad !== 0) begin miscompares++; $display("FAIL t2_gap_nop got bad=%0d/%0d exp 0", obs_gap_bad, obs_ab_bad); end
        vectors++; if (obs_unstable !== 0) begin miscompares++; $display("FAIL t2_hold got=%0d exp=0", obs_unstable); end
    endtask

    task automatic test_len_zero();
        qa.delete(); qb.delete(); qgap.delete();
        run_job(0, 0, 200, 0);
        vectors++; if (obs_data !== 0) begin miscompares++; $display("FAIL t3_data got=%0d exp=0", obs_data); end
        vectors++; if (obs_lat !== 3) begin miscompares++; $display("FAIL t3_latency got=%0d exp=3", obs_lat); end
        vectors++; if (obs_mac !== 0 || obs_clr !== 1) begin miscompares++; $display("FAIL t3_issue got mac=%0d clr=%0d exp mac=0 clr=1", obs_mac, obs_clr); end
    endtask

    task automatic test_start_in_run_and_reset();
        int waited = 0;
        start = 1'b1; len = LEN_W'(3); op_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!op_ready && waited < 10) begin @(posedge clk); #1; waited++; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({busy, op_ready, alu_acc_clr} !== 3'b110) begin
            miscompares++; $display("FAIL t4_start_ignored got busy/rdy/clr=%b exp=110", {busy, op_ready, alu_acc_clr});
        end
        op_valid = 1'b1; op_a = 8'd7; op_b = 8'd9;
        #1;
        vectors++;
        if (alu_opcode !== MAC_OP || alu_a !== 8'd7) begin
            miscompares++; $display("FAIL t4_mac_in_run got op=%h a=%0d exp op=6 a=7", alu_opcode, alu_a);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, op_ready, res_valid, res_err, alu_acc_clr, res_data, alu_a, alu_b, alu_opcode}
            !== {5'b0, 24'h0, NOP_OP}) begin
            miscompares++;
            $display("FAIL t4_async_reset got busy=%b rdy=%b rv=%b clr=%b data=%0d a=%0d op=%h",
                     busy, op_ready, res_valid, alu_acc_clr, res_data, alu_a, alu_opcode);
        end
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        @(posedge clk); #1;
        qa = '{8'd3}; qb = '{8'd4}; qgap = '{0};
        run_job(1, 0, 200, 1);
        vectors++; if (obs_data !== 12) begin miscompares++; $display("FAIL t4_next_job got=%0d exp=12", obs_data); end
        vectors++; if (obs_post_busy !== 0) begin miscompares++; $display("FAIL t4_handoff_start got=%0d exp=0", obs_post_busy); end
    endtask

    task automatic test_wrap();
        qa = '{8'd255, 8'd255}; qb = '{8'd255, 8'd255}; qgap = '{0, 0};
        run_job(2, 1, 200, 0);
        vectors++; if (obs_data !== 2) begin miscompares++; $display("FAIL t5_wrap got=%0d exp=2", obs_data); end
        vectors++; if (obs_err !== 0) begin miscompares++; $display("FAIL t5_err got=%0d exp=0", obs_err); end
    endtask

    task automatic test_timeout();
        qa = '{8'd5, 8'd6}; qb = '{8'd7, 8'd8}; qgap = '{0, 1000};
`ifdef MAC_TIMEOUT_EN
        run_job(2, 1, 200, 0);
        vectors++; if (obs_err !== 1 || obs_data !== 0) begin miscompares++; $display("FAIL t6_abort got err=%0d data=%0d exp err=1 data=0", obs_err, obs_data); end
        vectors++; if (obs_lat !== 19) begin miscompares++; $display("FAIL t6_latency got=%0d exp=19", obs_lat); end
        vectors++; if (obs_post_busy !== 0 || res_err !== 1'b0) begin miscompares++; $display("FAIL t6_err_clear got busy=%0d err=%b exp 0", obs_post_busy, res_err); end
`else
        run_job(2, 0, 100, 0);
        vectors++;
        if (obs_timed_out !== 1 || {busy, op_ready, res_valid, res_err} !== 4'b1100) begin
            miscompares++;
            $display("FAIL t6_wait_forever got to=%0d busy/rdy/rv/err=%b exp to=1 1100",
                     obs_timed_out, {busy, op_ready, res_valid, res_err});
        end
        vectors++; if (obs_mac !== 1) begin miscompares++; $display("FAIL t6_one_pair got=%0d exp=1", obs_mac); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_random();
        for (int j = 0; j < 20; j++) begin
            int n, rdly, exp_data, exp_lat;
            n = $urandom_range(0, 15);
            rdly = $urandom_range(0, 4);
            qa.delete(); qb.delete(); qgap.delete();
            for (int k = 0; k < n; k++) begin
                qa.push_back(WIDTH'($urandom));
                qb.push_back(WIDTH'($urandom));
                qgap.push_back(($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
            end
            exp_data = ref_sum();
            exp_lat = ref_latency(n);
            run_job(n, rdly, 200, j[0]);
            vectors++; if (obs_data !== exp_data) begin miscompares++; $display("FAIL rnd%0d_data got=%0d exp=%0d", j, obs_data, exp_data); end
            vectors++; if (obs_lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", j, obs_lat, exp_lat); end
            vectors++; if (obs_mac !== n || obs_clr !== 1) begin miscompares++; $display("FAIL rnd%0d_issue got mac=%0d clr=%0d exp mac=%0d clr=1", j, obs_mac, obs_clr, n); end
            vectors++;
            if (obs_ab_bad !== 0 || obs_gap_bad !== 0 || obs_unstable !== 0 || obs_err !== 0 || obs_post_busy !== 0) begin
                miscompares++;
                $display("FAIL rnd%0d_protocol got ab=%0d gap=%0d unstable=%0d err=%0d post=%0d exp all 0",
                         j, obs_ab_bad, obs_gap_bad, obs_unstable, obs_err, obs_post_busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_gap_backpressure();
        test_len_zero();
        test_start_in_run_and_reset();
        test_wrap();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
